// File: rtl/riscv_pkg.sv
`default_nettype none
// =============================================================================
// Package : riscv_pkg
// Desc    : Shared RV32I pipeline constants, fetch FSM state encoding and
//           redirect-target helper.
// Rev     : 1.0  initial release
// =============================================================================
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  // Raw redirect target before word alignment; jalr clears bit 0 first.
  function automatic logic [31:0] raw_redirect_target(
    input logic        is_jalr,
    input logic [31:0] alu_result,
    input logic [31:0] pc_target
  );
    logic [31:0] tgt;
    tgt = is_jalr ? {alu_result[31:1], 1'b0} : pc_target;
    return tgt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ifid_reg.sv
`default_nettype none
// =============================================================================
// Module  : fetch_ifid_reg
// Desc    : IF/ID pipeline register. Flush beats stall; an unstalled cycle
//           without a new instruction inserts a NOP bubble.
// Rev     : 1.0  initial release
// =============================================================================
module fetch_ifid_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pcplus4_q;
  logic            valid_q;

  // Bubbles keep PC fields so ID still sees the last real PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i || (!stall_i && !load_i)) begin
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
    end else if (!stall_i) begin
      instr_q   <= instr_i;
      pc_q      <= pc_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module  : fetch_unit
// Desc    : RV32I IF stage: owns PCF, single-outstanding imem request FSM,
//           skid buffer and IF/ID register. Define FETCH_MISALIGN_TRAP_EN to
//           add the misalign_trapE output.
// Rev     : 1.0  initial release
// =============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic            PCJalSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusyF
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trapE
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            drop_q, drop_d;

  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pcf_plus4;
  logic            ifid_load;
  logic [XLEN-1:0] ifid_instr;
  logic            unused_bits;

  assign raw_target  = raw_redirect_target(PCJalSrcE, ALUResultE, PCTargetE);
  assign target      = {raw_target[XLEN-1:2], 2'b00};
  assign pcf_plus4   = pcf_q + 32'd4;
  assign unused_bits = ^{raw_target[1:0], ALUResultE[0]};

  always_comb begin
    state_d        = state_q;
    pcf_d          = pcf_q;
    drop_d         = drop_q;
    skid_d         = skid_q;
    skid_valid_d   = skid_valid_q;
    ifid_load      = 1'b0;
    ifid_instr     = imem_rsp_data;
    imem_req_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!StallF) state_d = S_REQ;
      end
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StallF ? S_IDLE : S_REQ;
          end else if (StallD) begin
            skid_d       = imem_rsp_data;
            skid_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            ifid_load = 1'b1;
            pcf_d     = pcf_plus4;
            state_d   = StallF ? S_IDLE : S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!StallD) begin
          ifid_load    = 1'b1;
          ifid_instr   = skid_q;
          skid_valid_d = 1'b0;
          pcf_d        = pcf_plus4;
          state_d      = StallF ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides any same-cycle delivery. A request already on the
    // bus (or in flight) must still complete, so its response is marked for
    // dropping unless it is the one arriving right now.
    if (PCSrcE) begin
      pcf_d        = target;
      skid_valid_d = 1'b0;
      ifid_load    = 1'b0;
      if (state_q == S_REQ) begin
        drop_d = 1'b1;
      end else if (state_q == S_WAIT) begin
        if (imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = StallF ? S_IDLE : S_REQ;
        end else begin
          drop_d = 1'b1;
        end
      end else if (state_q == S_HOLD) begin
        state_d = StallF ? S_IDLE : S_REQ;
      end
    end
  end

  // Address is frozen while a request is presented so it stays stable until accept.
  assign req_addr_d = (state_q == S_REQ) ? req_addr_q : pcf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pcf_q        <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_q       <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      req_addr_q   <= req_addr_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign imem_addr  = req_addr_q;
  assign FetchBusyF = !(((state_q == S_WAIT) && imem_rsp_valid && !drop_q) || skid_valid_q);

  fetch_ifid_reg #(
    .XLEN (XLEN)
  ) u_ifid (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (FlushD),
    .stall_i   (StallD),
    .load_i    (ifid_load),
    .instr_i   (ifid_instr),
    .pc_i      (pcf_q),
    .pcplus4_i (pcf_plus4),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pcplus4_o (PCPlus4D),
    .valid_o   (ValidD)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= PCSrcE && (raw_target[1:0] != 2'b00);
    end
  end

  assign misalign_trapE = trap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module  : tb_fetch_unit
// Desc    : Self-checking bench for fetch_unit with a one-outstanding imem
//           responder and an expected-delivery scoreboard.
// Rev     : 1.0  initial release
// =============================================================================
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic        PCSrcE = 1'b0, PCJalSrcE = 1'b0;
  logic [31:0] PCTargetE = '0, ALUResultE = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusyF;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trapE;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  int          acc_cyc_q[$];
  int          rsp_delay = 1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCJalSrcE      (PCJalSrcE),
    .PCTargetE      (PCTargetE),
    .ALUResultE     (ALUResultE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD),
    .FetchBusyF     (FetchBusyF)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trapE (misalign_trapE)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[19:0], 12'h000};
  endfunction

  // Instruction memory: sees an accept mid-cycle, answers rsp_delay cycles later.
  initial begin
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && !reset) begin
        a = imem_addr;
        acc_q.push_back(a);
        acc_cyc_q.push_back(cyc);
        repeat (rsp_delay) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(a);
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCJalSrcE = 1'b0; PCTargetE = '0; ALUResultE = '0;
    imem_req_ready = rdy;
    repeat (4) step();
    reset = 1'b0;
    acc_q.delete();
    acc_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_acc(input int n, output bit ok);
    ok = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      if (acc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Pops the next expected delivery and checks the IF/ID contents against it.
  task automatic check_delivery(input string name, input bit ok);
    exp_t e;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: timed out waiting for ValidD", name);
    end else if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected delivery PCD=%h InstrD=%h", name, PCD, InstrD);
    end else begin
      e = exp_q.pop_front();
      if ({PCD, InstrD, PCPlus4D, ValidD} !== {e.pc, e.instr, e.pc + 32'd4, 1'b1}) begin
        n_bad++;
        $display("FAIL %s: got PCD=%h InstrD=%h PCPlus4D=%h ValidD=%b want PCD=%h InstrD=%h PCPlus4D=%h ValidD=1",
                 name, PCD, InstrD, PCPlus4D, ValidD, e.pc, e.instr, e.pc + 32'd4);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_req_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, imem_addr, ValidD, FetchBusyF} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got req_valid=%b addr=%h ValidD=%b busy=%b want 0 00000000 0 1",
               imem_req_valid, imem_addr, ValidD, FetchBusyF);
    end
    n_cmp++;
    if ({InstrD, PCD, PCPlus4D} !== {NOP_INSTR, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_ifid: got InstrD=%h PCD=%h PCPlus4D=%h want 00000013 00000000 00000000",
               InstrD, PCD, PCPlus4D);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++;
    if (misalign_trapE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_trap: got %b want 0", misalign_trapE);
    end
`endif
  endtask

  task automatic test_sequential();
    bit ok;
    int first_cyc;
    rsp_delay = 1;
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) exp_q.push_back('{32'(k * 4), mem_word(32'(k * 4))});
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      first_cyc = cyc;
      check_delivery("seq_deliver", ok);
      if (k == 0 && ok) begin
        n_cmp++;
        if (acc_cyc_q.size() == 0 || first_cyc !== acc_cyc_q[0] + 2) begin
          n_bad++;
          $display("FAIL seq_latency: InstrD valid in cycle %0d, accept cycle %0d, want accept+2",
                   first_cyc, (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -1);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (acc_q.size() <= k || acc_q[k] !== 32'(k * 4)) begin
        n_bad++;
        $display("FAIL seq_addr: request %0d got %h want %h", k,
                 (acc_q.size() > k) ? acc_q[k] : 32'hxxxx_xxxx, 32'(k * 4));
      end
    end
  endtask

  task automatic test_redirect_drop();
    bit ok;
    rsp_delay = 3;
    do_reset(1'b1);
    exp_q.push_back('{32'h0, mem_word(32'h0)});
    exp_q.push_back('{32'h4, mem_word(32'h4)});
    wait_valid(ok);
    check_delivery("redir_pre0", ok);
    wait_valid(ok);
    check_delivery("redir_pre4", ok);
    wait_acc(3, ok);
    PCSrcE = 1'b1;
    PCTargetE = 32'h0000_0100;
    exp_q.push_back('{32'h100, mem_word(32'h100)});
    step();
    PCSrcE = 1'b0;
    wait_valid(ok);
    check_delivery("redir_drop", ok);
    n_cmp++;
    if (acc_q.size() < 4 || acc_q[2] !== 32'h8 || acc_q[3] !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_addr: got %0d requests, third=%h fourth=%h want 00000008 00000100",
               acc_q.size(), (acc_q.size() > 2) ? acc_q[2] : 32'hx, (acc_q.size() > 3) ? acc_q[3] : 32'hx);
    end
  endtask

  task automatic test_jalr();
    bit ok;
    rsp_delay = 1;
    do_reset(1'b1);
    exp_q.push_back('{32'h0, mem_word(32'h0)});
    wait_valid(ok);
    check_delivery("jalr_pre", ok);
    step();
    PCSrcE = 1'b1;
    PCJalSrcE = 1'b1;
    ALUResultE = 32'h0000_0203;
    PCTargetE = 32'h0000_0444;
    exp_q.push_back('{32'h200, mem_word(32'h200)});
    step();
    PCSrcE = 1'b0;
    PCJalSrcE = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    n_cmp++;
    if (misalign_trapE !== 1'b1) begin
      n_bad++;
      $display("FAIL jalr_trap_on: got %b want 1", misalign_trapE);
    end
    @(negedge clk);
    n_cmp++;
    if (misalign_trapE !== 1'b0) begin
      n_bad++;
      $display("FAIL jalr_trap_off: got %b want 0", misalign_trapE);
    end
`endif
    wait_valid(ok);
    check_delivery("jalr_target", ok);
  endtask

  task automatic test_wrap();
    bit ok;
    rsp_delay = 1;
    do_reset(1'b1);
    exp_q.push_back('{32'h0, mem_word(32'h0)});
    wait_valid(ok);
    check_delivery("wrap_pre", ok);
    step();
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    exp_q.push_back('{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    exp_q.push_back('{32'h0, mem_word(32'h0)});
    step();
    PCSrcE = 1'b0;
    wait_valid(ok);
    check_delivery("wrap_top", ok);
    wait_valid(ok);
    check_delivery("wrap_zero", ok);
  endtask

  task automatic test_stall_hold();
    bit ok;
    rsp_delay = 1;
    do_reset(1'b1);
    exp_q.push_back('{32'h0, mem_word(32'h0)});
    exp_q.push_back('{32'h4, mem_word(32'h4)});
    wait_valid(ok);
    check_delivery("hold_pre", ok);
    StallD = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({PCD, InstrD, ValidD, imem_req_valid} !== {32'h0, mem_word(32'h0), 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL hold_stall: cycle %0d got PCD=%h InstrD=%h ValidD=%b req_valid=%b want 00000000 %h 1 0",
                 k, PCD, InstrD, ValidD, imem_req_valid, mem_word(32'h0));
      end
      if (k == 2) begin
        n_cmp++;
        if (FetchBusyF !== 1'b0) begin
          n_bad++;
          $display("FAIL hold_busy: got %b want 0", FetchBusyF);
        end
      end
    end
    StallD = 1'b0;
    @(negedge clk);
    check_delivery("hold_release", 1'b1);
  endtask

  task automatic test_ready_flush();
    bit ok;
    rsp_delay = 1;
    do_reset(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (!ok || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
        n_bad++;
        $display("FAIL ready_hold: cycle %0d got req_valid=%b addr=%h want 1 00000000", k, imem_req_valid, imem_addr);
      end
    end
    step();
    imem_req_ready = 1'b1;
    exp_q.push_back('{32'h0, mem_word(32'h0)});
    exp_q.push_back('{32'h4, mem_word(32'h4)});
    wait_valid(ok);
    check_delivery("ready_first", ok);
    FlushD = 1'b1;
    StallD = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP_INSTR, 32'h0, 32'h4}) begin
      n_bad++;
      $display("FAIL flush: got ValidD=%b InstrD=%h PCD=%h PCPlus4D=%h want 0 00000013 00000000 00000004",
               ValidD, InstrD, PCD, PCPlus4D);
    end
    FlushD = 1'b0;
    StallD = 1'b0;
    wait_valid(ok);
    check_delivery("flush_after", ok);
  endtask

  task automatic test_reset_midwait();
    bit ok;
    rsp_delay = 2;
    do_reset(1'b1);
    wait_acc(3, ok);
    reset = 1'b1;
    step();
    reset = 1'b0;
    acc_q.delete();
    exp_q.push_back('{32'h0, mem_word(32'h0)});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ValidD !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_ignore: cycle %0d got ValidD=%b PCD=%h want ValidD=0", k, ValidD, PCD);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_cmp++;
    if (!ok || acc_q[0] !== RESET_PC_DEFAULT) begin
      n_bad++;
      $display("FAIL rst_first_addr: got %h want %h", ok ? acc_q[0] : 32'hx, RESET_PC_DEFAULT);
    end
    wait_valid(ok);
    check_delivery("rst_first_instr", ok);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_drop();
    test_jalr();
    test_wrap();
    test_stall_hold();
    test_ready_flush();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
